// File: rtl/pc_sequencer_if.sv
// Fetch-stage control/status bundle between decode logic and the PC sequencer.
// The master drives next-PC controls; the slave (sequencer) returns PC and RAS status.
interface pc_sequencer_if #(
    parameter int XLEN    = 32,
    parameter int B_IMM_W = 16,
    parameter int J_IMM_W = 26
);
    logic               stall;
    logic               redirect;
    logic [XLEN-1:0]    redirect_addr;
    logic [B_IMM_W-1:0] immediate16;
    logic [J_IMM_W-1:0] immediate26;
    logic               zero;
    logic               jump;
    logic               jump_link;
    logic               jump_ret;
    logic               branch_on_eq;
    logic               branch_on_neq;
    logic [XLEN-1:0]    pc;
    logic [XLEN-1:0]    pc_plus4;
    logic               pc_src;
    logic [XLEN-1:0]    target_address;
    logic               ras_empty;
    logic               ras_full;
    logic               ras_overflow;
    logic               ras_underflow;

    modport master (
        output stall, redirect, redirect_addr, immediate16, immediate26, zero,
               jump, jump_link, jump_ret, branch_on_eq, branch_on_neq,
        input  pc, pc_plus4, pc_src, target_address,
               ras_empty, ras_full, ras_overflow, ras_underflow
    );

    modport slave (
        input  stall, redirect, redirect_addr, immediate16, immediate26, zero,
               jump, jump_link, jump_ret, branch_on_eq, branch_on_neq,
        output pc, pc_plus4, pc_src, target_address,
               ras_empty, ras_full, ras_overflow, ras_underflow
    );
endinterface

// File: rtl/pc_sequencer.sv
// Registered program counter with branch/jump/call/return selection and a
// circular return-address stack; external redirect overrides everything, even stall.
module pc_sequencer #(
    parameter int              XLEN      = 32,
    parameter int              B_IMM_W   = 16,
    parameter int              J_IMM_W   = 26,
    parameter int              RAS_DEPTH = 4,
    parameter logic [XLEN-1:0] RESET_VEC = '0
) (
    input  logic         clk,
    input  logic         reset,
    pc_sequencer_if.slave bus
);
    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [XLEN-1:0]  pc_q;
    logic [XLEN-1:0]  pc_plus4;
    logic [XLEN-1:0]  ras_mem [RAS_DEPTH];
    logic [PTR_W-1:0] top_ptr;            // next free slot; top entry sits just below
    logic [CNT_W-1:0] ras_count;
    logic             overflow_q;
    logic             underflow_q;

    logic [XLEN-1:0]  branch_tgt;
    logic [XLEN-1:0]  jump_tgt;
    logic [XLEN-1:0]  ret_tgt;
    logic             taken;
    logic             ras_empty;
    logic             ras_full;
    logic             pc_src;
    logic [XLEN-1:0]  target;
    logic             do_push;
    logic             do_pop;

    assign pc_plus4   = pc_q + XLEN'(4);
    assign ras_empty  = (ras_count == '0);
    assign ras_full   = (ras_count == CNT_W'(RAS_DEPTH));
    assign branch_tgt = pc_q + {{(XLEN-B_IMM_W-2){bus.immediate16[B_IMM_W-1]}},
                                bus.immediate16, 2'b00};
    assign jump_tgt   = {pc_q[XLEN-1:J_IMM_W+2], bus.immediate26, 2'b00};
    assign ret_tgt    = ras_empty ? pc_plus4 : ras_mem[top_ptr - PTR_W'(1)];
    assign taken      = (bus.branch_on_eq & bus.zero) | (bus.branch_on_neq & ~bus.zero);

    // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
    always_comb begin
        pc_src = 1'b1;
        target = '0;
        if (bus.redirect)                      target = bus.redirect_addr;
        else if (bus.jump_ret)                 target = ret_tgt;
        else if (bus.jump || bus.jump_link)    target = jump_tgt;
        else if (taken)                        target = branch_tgt;
        else                                   pc_src = 1'b0;
    end

    // A return in the same cycle as a call wins and suppresses the push.
    assign do_push = ~bus.stall & ~bus.redirect & bus.jump_link & ~bus.jump_ret;
    assign do_pop  = ~bus.stall & ~bus.redirect & bus.jump_ret;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q        <= RESET_VEC;
            top_ptr     <= '0;
            ras_count   <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (bus.redirect)   pc_q <= bus.redirect_addr;
            else if (!bus.stall) pc_q <= pc_src ? target : pc_plus4;

            if (do_push) begin
                top_ptr <= top_ptr + PTR_W'(1);
                if (ras_full) overflow_q <= 1'b1;     // oldest entry overwritten
                else          ras_count  <= ras_count + CNT_W'(1);
            end

            if (do_pop) begin
                if (ras_empty) begin
                    underflow_q <= 1'b1;
                end else begin
                    top_ptr   <= top_ptr - PTR_W'(1);
                    ras_count <= ras_count - CNT_W'(1);
                end
            end
        end
    end

    // NOTE: stack storage is not reset; entries are only read when ras_count says
    // they were written, so clearing them would cost logic for no behaviour.
    always_ff @(posedge clk) begin
        if (do_push) ras_mem[top_ptr] <= pc_plus4;
    end

    assign bus.pc             = pc_q;
    assign bus.pc_plus4       = pc_plus4;
    assign bus.pc_src         = pc_src;
    assign bus.target_address = target;
    assign bus.ras_empty      = ras_empty;
    assign bus.ras_full       = ras_full;
    assign bus.ras_overflow   = overflow_q;
    assign bus.ras_underflow  = underflow_q;
endmodule
